// File: rtl/axis_maxpool2x2_if.sv
// axis_maxpool2x2_if: AXI-Stream beat bundle (data/valid/ready/last) with master and slave views
interface axis_maxpool2x2_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;
   logic             last;
   modport master(output data, valid, last, input ready);
   modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/axis_maxpool2x2.sv
// axis_maxpool2x2: streaming 2x2 stride-2 max pooling on AXI-Stream, one pooled word per window
module axis_maxpool2x2 #(
   parameter int WIDTH  = 32,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter bit SIGNED = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   axis_maxpool2x2_if.slave  s_axis,
   axis_maxpool2x2_if.master m_axis,
   output logic              o_done
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int NL = IMG_W / 2;
   localparam int LW = NL > 1 ? $clog2(NL) : 1;
   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [WIDTH-1:0] r_h;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] r_lb [NL];
   logic             r_valid;
   logic             r_last;
   logic             r_done;
   logic             w_ready;
   logic             w_acc;
   logic             w_col_end;
   logic             w_row_end;
   logic             w_emit;
   logic             w_fill;
   logic [LW-1:0]    w_idx;
   logic [WIDTH-1:0] w_pm;
   logic [WIDTH-1:0] w_lbv;
   logic [WIDTH-1:0] w_win;
   function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return SIGNED ? $signed(a) > $signed(b) : a > b;
   endfunction
   always_comb begin
      w_ready   = !r_valid || m_axis.ready;
      w_acc     = s_axis.valid && w_ready;
      w_col_end = r_col == CW'(IMG_W - 1);
      w_row_end = r_row == RW'(IMG_H - 1);
      w_emit    = w_acc && r_col[0] && r_row[0];
      w_fill    = w_acc && r_col[0] && !r_row[0];
      w_idx     = LW'(r_col >> 1);
      w_pm      = gt(r_h, s_axis.data) ? r_h : s_axis.data;
      w_lbv     = r_lb[w_idx];
      w_win     = gt(w_lbv, w_pm) ? w_lbv : w_pm;
   end
   // Line buffer holds even-row pair maxima; every entry is rewritten before its odd-row read
   always_ff @(posedge i_clk) begin
      if (w_fill) r_lb[w_idx] <= w_pm;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_col   <= '0;
         r_row   <= '0;
         r_h     <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (w_acc) begin
            if (!r_col[0]) r_h <= s_axis.data;
            r_col <= w_col_end ? '0 : r_col + 1'b1;
            if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
         end
         if (w_emit) begin
            r_data  <= w_win;
            r_valid <= 1'b1;
            r_last  <= w_row_end && w_col_end;
         end else if (m_axis.ready) begin
            r_valid <= 1'b0;
         end
         r_done <= r_valid && m_axis.ready && r_last;
      end
   end
   assign s_axis.ready = w_ready;
   assign m_axis.data  = r_data;
   assign m_axis.valid = r_valid;
   assign m_axis.last  = r_last;
   assign o_done       = r_done;
endmodule

// File: tb/tb_axis_maxpool2x2.sv
// tb_axis_maxpool2x2: directed checks of pooled values, handshakes, frame markers and reset
module tb_axis_maxpool2x2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic done, done_s, done_u;
   int checks = 0;
   int failures = 0;
   int acc_cnt = 0;
   int done_cnt = 0;
   logic [32:0] q[$];
   logic prev_last_hs = 1'b0;
   logic prev_done = 1'b0;
   always #5 clk = ~clk;
   axis_maxpool2x2_if #(.WIDTH(32)) s_if ();
   axis_maxpool2x2_if #(.WIDTH(32)) m_if ();
   axis_maxpool2x2_if #(.WIDTH(32)) s2_if ();
   axis_maxpool2x2_if #(.WIDTH(32)) m2s_if ();
   axis_maxpool2x2_if #(.WIDTH(32)) u2_if ();
   axis_maxpool2x2_if #(.WIDTH(32)) m2u_if ();
   axis_maxpool2x2 #(.WIDTH(32), .IMG_W(8), .IMG_H(8), .SIGNED(1)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .s_axis(s_if), .m_axis(m_if), .o_done(done));
   axis_maxpool2x2 #(.WIDTH(32), .IMG_W(2), .IMG_H(2), .SIGNED(1)) u_sgn (
      .i_clk(clk), .i_rst_n(rst_n), .s_axis(s2_if), .m_axis(m2s_if), .o_done(done_s));
   axis_maxpool2x2 #(.WIDTH(32), .IMG_W(2), .IMG_H(2), .SIGNED(0)) u_uns (
      .i_clk(clk), .i_rst_n(rst_n), .s_axis(u2_if), .m_axis(m2u_if), .o_done(done_u));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   always @(posedge clk) if (s_if.valid && s_if.ready) acc_cnt <= acc_cnt + 1;
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         chk("done_after_last", 64'(prev_last_hs), 64'd1);
         chk("done_width", 64'(prev_done), 64'd0);
      end
      prev_done = done;
      prev_last_hs = m_if.valid && m_if.ready && m_if.last && rst_n;
      if (m_if.valid && m_if.ready && rst_n) q.push_back({m_if.last, m_if.data});
   end
   task automatic send(input logic [31:0] v);
      int n0, t;
      s_if.data = v;
      s_if.valid = 1'b1;
      n0 = acc_cnt;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (acc_cnt == n0 && t < 50);
      chk("beat_accepted", 64'(acc_cnt - n0), 64'd1);
   endtask
   task automatic send_frame(input int off, input bit gaps);
      for (int i = 0; i < 64; i++) begin
         send(32'(i + off));
         if (gaps) begin
            s_if.valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      s_if.valid = 1'b0;
   endtask
   task automatic check_out(input int nf);
      int i;
      logic [32:0] e;
      i = 0;
      repeat (4) @(posedge clk);
      #1;
      chk("out_count", 64'(q.size()), 64'(16 * nf));
      for (int f = 0; f < nf; f++)
         for (int pr = 0; pr < 4; pr++)
            for (int pc = 0; pc < 4; pc++) begin
               e = {pr == 3 && pc == 3, 32'(16 * pr + 2 * pc + 9 + 100 * f)};
               if (i < q.size()) chk("out_word", 64'(q[i]), 64'(e));
               i++;
            end
      q.delete();
   endtask
   task automatic send2(input logic [31:0] a, b, c, d, input logic [31:0] es, eu);
      logic [31:0] v[4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      s2_if.valid = 1'b1;
      u2_if.valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s2_if.data = v[i];
         u2_if.data = v[i];
         @(posedge clk);
         #1;
      end
      s2_if.valid = 1'b0;
      u2_if.valid = 1'b0;
      chk("sgn_valid", 64'(m2s_if.valid), 64'd1);
      chk("sgn_data", 64'(m2s_if.data), 64'(es));
      chk("sgn_last", 64'(m2s_if.last), 64'd1);
      chk("uns_data", 64'(m2u_if.data), 64'(eu));
      @(posedge clk);
      #1;
      chk("sgn_done", 64'(done_s), 64'd1);
      chk("uns_done", 64'(done_u), 64'd1);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      int n;
      s_if.data = '0; s_if.valid = 1'b0; s_if.last = 1'b0; m_if.ready = 1'b1;
      s2_if.data = '0; s2_if.valid = 1'b0; s2_if.last = 1'b0; m2s_if.ready = 1'b1;
      u2_if.data = '0; u2_if.valid = 1'b0; u2_if.last = 1'b0; m2u_if.ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(m_if.valid), 64'd0);
      chk("rst_data", 64'(m_if.data), 64'd0);
      chk("rst_last", 64'(m_if.last), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ready", 64'(s_if.ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // plain ramp with output latency probes around the first window
      done_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         send(32'(i));
         if (i == 8) chk("lat_before", 64'(m_if.valid), 64'd0);
         if (i == 9) begin
            chk("lat_valid", 64'(m_if.valid), 64'd1);
            chk("lat_data", 64'(m_if.data), 64'd9);
         end
      end
      s_if.valid = 1'b0;
      check_out(1);
      chk("ramp_done_cnt", 64'(done_cnt), 64'd1);
      // backpressure on the first pooled word
      done_cnt = 0;
      m_if.ready = 1'b0;
      for (int i = 0; i < 10; i++) send(32'(i));
      s_if.data = 32'd10;
      s_if.valid = 1'b1;
      n = acc_cnt;
      repeat (5) begin
         @(negedge clk);
         chk("bp_ready", 64'(s_if.ready), 64'd0);
         chk("bp_valid", 64'(m_if.valid), 64'd1);
         chk("bp_hold", 64'(m_if.data), 64'd9);
         @(posedge clk);
         #1;
      end
      chk("bp_no_consume", 64'(acc_cnt - n), 64'd0);
      m_if.ready = 1'b1;
      for (int i = 10; i < 64; i++) send(32'(i));
      s_if.valid = 1'b0;
      check_out(1);
      chk("bp_done_cnt", 64'(done_cnt), 64'd1);
      // input gaps every other cycle
      done_cnt = 0;
      send_frame(0, 1'b1);
      check_out(1);
      chk("gap_done_cnt", 64'(done_cnt), 64'd1);
      // two frames back to back
      done_cnt = 0;
      send_frame(0, 1'b0);
      send_frame(100, 1'b0);
      check_out(2);
      chk("b2b_done_cnt", 64'(done_cnt), 64'd2);
      // reset in the middle of a frame
      for (int i = 0; i < 20; i++) send(32'(i));
      s_if.valid = 1'b0;
      m_if.ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 64'(m_if.valid), 64'd0);
      chk("mid_rst_ready", 64'(s_if.ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_if.ready = 1'b1;
      q.delete();
      done_cnt = 0;
      send_frame(0, 1'b0);
      check_out(1);
      chk("rst_done_cnt", 64'(done_cnt), 64'd1);
      // signed vs unsigned comparison on a single 2x2 window
      send2(32'hFFFFFFFB, 32'hFFFFFFFD, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      send2(32'hFFFFFFFF, 32'd2, 32'd0, 32'd1, 32'd2, 32'hFFFFFFFF);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axis_maxpool2x2.md
# axis_maxpool2x2

Streaming 2x2 stride-2 max-pooling stage on AXI-Stream. It sits directly downstream of the AXIS wait/buffer stage and consumes that stage's row-major feature-map beats (`m_data`/`m_valid`/`m_ready` on that side). It emits one pooled word per 2x2 window on its own AXIS master. One internal line buffer of `IMG_W/2` partial maxima; no frame buffer.

## Interface
Parameters:
- `WIDTH`, 32, data word width
- `IMG_W`, 8, input frame width in beats; even, ≥2
- `IMG_H`, 8, input frame height in rows; even, ≥2
- `SIGNED`, 1, 1 = compare as two's complement, 0 = unsigned

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `s_data`  in  WIDTH  input pixel, row-major
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`
- `m_data`  out  WIDTH  pooled output word
- `m_valid`  out  1  output valid
- `m_ready`  in  1  downstream ready
- `m_last`  out  1  qualifies final pooled word of a frame
- `done`  out  1  one-cycle pulse: frame's last output handshaken

## Operation
- Counters: `col` 0..IMG_W-1, `row` 0..IMG_H-1.
  - Advance only on an accepted input beat.
  - `col` wraps to 0 and increments `row`.
  - After the beat (IMG_H-1, IMG_W-1), both counters wrap to 0. The next frame starts with no gap.
- Even `col`: capture beat into holding register `h`.
- Odd `col`: pair max `pm = max(h, s_data)`.
  - Even `row`: write `lb[col>>1] <= pm`. No output.
  - Odd `row`: `m_data <= max(lb[col>>1], pm)`, `m_valid <= 1`.
  - `m_last <= (row==IMG_H-1 && col==IMG_W-1)`.
- Comparison per `SIGNED`. Ties yield the equal value; which operand is chosen is irrelevant.
- Output register is single-entry.
  - `m_valid` holds, and `m_data`/`m_last` stay stable, until `m_valid && m_ready`.
  - On handshake without a new result in the same cycle, `m_valid` falls.
  - On handshake with a new result in the same cycle, the register reloads and `m_valid` stays 1.
- Input stall rule: `s_ready = !m_valid || m_ready`, combinational from registered `m_valid` and `m_ready`. Backpressure only blocks input while an unconsumed output exists.
- `done`:
  - Asserted the cycle after the `m_last` word handshakes, for exactly 1 cycle.
  - If a new frame's beats are flowing meanwhile, they are unaffected.
- Output count per frame: (IMG_W/2)*(IMG_H/2), in row-major pooled order.
- Line buffer is a plain register array of IMG_W/2 x WIDTH, not reset. Each entry is always written on an even row before it is read on the following odd row.

## Timing
- Reset values:
  - `m_valid=0`, `m_data=0`, `m_last=0`, `done=0`
  - `col=0`, `row=0`, `h=0`
  - `s_ready=1` during and after reset
- Reset mid-frame discards all partial state. The next accepted beat is treated as (row 0, col 0). An un-handshaken `m_valid` is dropped.
- Latency: `m_valid` rises the clock edge after acceptance of the odd-row/odd-col beat that completes a window, i.e. 1 cycle.
- Throughput:
  - 1 input beat/cycle sustained when `m_ready=1`.
  - Output rate is at most 1 word per 2 accepted beats on odd rows; 0 on even rows.
- `s_valid` gaps: counters and `h` hold; no output change.
- `m_ready` low with `m_valid=1`:
  - `s_ready=0`; input stalls.
  - Input beats on even rows are also stalled (conservative, fixed behaviour).
- `m_ready` is a don't-care when `m_valid=0`.
- Simultaneous output handshake and window completion: no bubble. `m_valid` stays 1 with the new data.

## Test plan
- **Ramp:** 8x8 frame `s_data=8r+c` (0..63), `m_ready=1`, continuous `s_valid` -> 16 outputs 9,11,13,15,25,27,29,31,41,43,45,47,57,59,61,63. `m_last` only with 63. `done` pulses 1 cycle after. Each output 1 cycle after its completing beat.
- **Signed:** `SIGNED=1`, window {-5,-3,-8,-1} (0xFFFFFFFB,0xFFFFFFFD,0xFFFFFFF8,0xFFFFFFFF) -> output 0xFFFFFFFF (-1).
  - Same data with `SIGNED=0` -> 0xFFFFFFFF.
  - Window {-1, 2, 0, 1} with `SIGNED=1` -> 2; with `SIGNED=0` -> 0xFFFFFFFF.
- **Backpressure:** ramp frame, `m_ready=0` for 5 cycles after first `m_valid` -> `m_data` held at 9, `s_ready=0`, no input consumed. After `m_ready=1`, remaining outputs are correct and in order, with no loss or duplicate.
- **Input gaps:** ramp with `s_valid` toggling 1/0 every cycle -> identical 16-word output sequence and `m_last` placement.
- **Back-to-back frames:** two ramp frames, second offset +100, no idle -> 32 outputs, second set 109..163 (+100 each). `m_last` twice, `done` twice.
- **Reset mid-frame:** assert `rst=0` after 20 beats, then release, then send a full ramp frame -> `m_valid=0` during reset, `s_ready=1`. Output is exactly the 16-word ramp sequence, with no stale words.
